image_streamer: RTL

Upstream feeder for the BNN accelerator top. It accepts binarized 28x28 image frames as 8-bit words over a valid/ready stream and holds them in a ping-pong pair of frame buffers. It issues the accelerator's one-cycle `start` pulse, then serializes the frame one pixel per cycle onto the accelerator's `image_in`. It waits for the accelerator's `done` before launching the next frame, so a host can load frame N+1 while frame N is being classified.

---
 rtl/bnn_pkg.sv | 28 ++
 rtl/frame_buf.sv | 25 ++
 rtl/image_streamer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// Shared constants, stream-state encoding and pixel-to-word mapping for the
// BNN image streamer and its testbench.
package bnn_pkg;

  localparam int IMG_BITS = 784;
  localparam int WORD_W   = 8;
  localparam int WORDS    = IMG_BITS / WORD_W;
  localparam int BIT_W    = $clog2(IMG_BITS + 1);
  localparam int IDX_W    = $clog2(WORDS + 1);
  localparam int SUB_W    = $clog2(WORD_W);

  typedef enum logic [1:0] {
    IDLE,
    START,
    STREAM,
    WAIT_DONE
  } stream_state_t;

  // Pixel k lives in word k/WORD_W; the word's MSB is the earliest pixel.
  function automatic logic [IDX_W-1:0] pix_word(input logic [BIT_W-1:0] k);
    return IDX_W'(k / BIT_W'(WORD_W));
  endfunction

  function automatic logic [SUB_W-1:0] pix_bit(input logic [BIT_W-1:0] k);
    return SUB_W'(BIT_W'(WORD_W - 1) - (k % BIT_W'(WORD_W)));
  endfunction

endpackage

// File: rtl/frame_buf.sv
// One frame of storage: WORDS x WORD_W registers, synchronous write,
// combinational read by word index.
module frame_buf
  import bnn_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The streamer prefetches one pixel past the end; keep that read in range.
  assign rdata = (raddr < IDX_W'(WORDS)) ? mem[raddr] : '0;

endmodule

// File: rtl/image_streamer.sv
// Ping-pong frame loader that launches the BNN accelerator and serializes
// each buffered frame onto its pixel input, one pixel per cycle.
module image_streamer
  import bnn_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              acc_done,
  output logic              acc_start,
  output logic              image_out,
  output logic              busy,
  output logic              frame_err
);

  logic [1:0]        full;
  logic [1:0]        full_set;
  logic [1:0]        full_clr;
  logic              wr_sel;
  logic              rd_sel;
  logic [IDX_W-1:0]  wr_idx;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  rd_bit;
  logic [IDX_W-1:0]  raddr;
  logic [WORD_W-1:0] rdata [2];
  logic [WORD_W-1:0] rword;
  logic [1:0]        we;
  logic              accept;
  logic              at_end;
  logic              frame_ok;
  logic              frame_bad;
  logic              done_evt;
  stream_state_t     state;
  stream_state_t     next_state;

  assign s_ready   = !full[wr_sel];
  assign accept    = s_valid && s_ready;
  assign at_end    = (wr_idx == IDX_W'(WORDS - 1));
  assign frame_ok  = accept && s_last && at_end;
  assign frame_bad = accept && (s_last != at_end);
  assign done_evt  = (state == WAIT_DONE) && acc_done;
  assign full_set  = frame_ok ? (wr_sel ? 2'b10 : 2'b01) : 2'b00;
  assign full_clr  = done_evt ? (rd_sel ? 2'b10 : 2'b01) : 2'b00;
  assign we[0]     = accept && !frame_bad && !wr_sel;
  assign we[1]     = accept && !frame_bad && wr_sel;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_buf u_buf (
      .clk   (clk),
      .we    (we[b]),
      .waddr (wr_idx),
      .wdata (s_data),
      .raddr (raddr),
      .rdata (rdata[b])
    );
  end

  // Read address points at the pixel that will be on image_out next cycle.
  assign rd_bit = (state == START) ? '0 : bit_cnt + BIT_W'(1);
  assign raddr  = pix_word(rd_bit);
  assign rword  = rd_sel ? rdata[1] : rdata[0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_idx    <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      full      <= 2'b00;
      frame_err <= 1'b0;
    end else begin
      if (frame_ok || frame_bad) begin
        wr_idx <= '0;
      end else if (accept) begin
        wr_idx <= wr_idx + IDX_W'(1);
      end
      if (frame_ok) begin
        wr_sel <= ~wr_sel;
      end
      if (done_evt) begin
        rd_sel <= ~rd_sel;
      end
      full      <= (full & ~full_clr) | full_set;
      frame_err <= frame_bad;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // IDLE also looks at the bank completing this cycle so start follows the last word directly.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (full[rd_sel] || full_set[rd_sel]) next_state = START;
      START:     next_state = STREAM;
      STREAM:    if (bit_cnt == BIT_W'(IMG_BITS - 1)) next_state = WAIT_DONE;
      WAIT_DONE: if (acc_done) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_start <= 1'b0;
      image_out <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      acc_start <= (next_state == START);
      image_out <= (next_state == STREAM) ? rword[pix_bit(rd_bit)] : 1'b0;
      if (state == START) begin
        bit_cnt <= '0;
      end else if (state == STREAM) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

endmodule
